// File: rtl/adder_pipe.sv
// rtl/adder_pipe.sv - segmented carry-pipelined adder/subtractor with valid/ready flow control
// Optional signed-overflow output enabled by defining ADDER_PIPE_OVF_EN.
module adder_pipe #(
    parameter int WIDTH = 32,
    parameter int SEG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef ADDER_PIPE_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NSEG = WIDTH / SEG_W;

    logic             w_en;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_c_eff;

    // Stage k input (from the ports for k=0, else from stage k-1 registers)
    logic             w_v_in   [NSEG];
    logic             w_c_in   [NSEG];
    logic [WIDTH-1:0] w_a_in   [NSEG];
    logic [WIDTH-1:0] w_b_in   [NSEG];
    logic [WIDTH-1:0] w_s_in   [NSEG];
    logic [SEG_W:0]   w_add    [NSEG];
    logic [WIDTH-1:0] w_s_nxt  [NSEG];
    logic             w_c_nxt  [NSEG];

    logic             r_v [NSEG];
    logic             r_c [NSEG];
    logic [WIDTH-1:0] r_a [NSEG];
    logic [WIDTH-1:0] r_b [NSEG];
    logic [WIDTH-1:0] r_s [NSEG];

    assign w_en     = !out_valid || out_ready;
    assign in_ready = w_en;
    assign w_b_eff  = sub ? ~b : b;
    assign w_c_eff  = sub ? 1'b1 : cin;

    always_comb begin
        w_v_in[0] = in_valid;
        w_c_in[0] = w_c_eff;
        w_a_in[0] = a;
        w_b_in[0] = w_b_eff;
        w_s_in[0] = '0;
        for (int k = 1; k < NSEG; k++) begin
            w_v_in[k] = r_v[k-1];
            w_c_in[k] = r_c[k-1];
            w_a_in[k] = r_a[k-1];
            w_b_in[k] = r_b[k-1];
            w_s_in[k] = r_s[k-1];
        end
        // Each stage resolves only its own segment; lower segments ride along unchanged
        for (int k = 0; k < NSEG; k++) begin
            w_add[k]   = {1'b0, w_a_in[k][k*SEG_W +: SEG_W]}
                       + {1'b0, w_b_in[k][k*SEG_W +: SEG_W]}
                       + {{SEG_W{1'b0}}, w_c_in[k]};
            w_s_nxt[k] = w_s_in[k];
            w_s_nxt[k][k*SEG_W +: SEG_W] = w_add[k][SEG_W-1:0];
            w_c_nxt[k] = w_add[k][SEG_W];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NSEG; k++) begin
                r_v[k] <= 1'b0;
                r_c[k] <= 1'b0;
                r_a[k] <= '0;
                r_b[k] <= '0;
                r_s[k] <= '0;
            end
        end else if (w_en) begin
            for (int k = 0; k < NSEG; k++) begin
                r_v[k] <= w_v_in[k];
                r_c[k] <= w_c_nxt[k];
                r_a[k] <= w_a_in[k];
                r_b[k] <= w_b_in[k];
                r_s[k] <= w_s_nxt[k];
            end
        end
    end

    assign out_valid = r_v[NSEG-1];
    assign sum       = r_s[NSEG-1];
    assign cout      = r_c[NSEG-1];

`ifdef ADDER_PIPE_OVF_EN
    // Operands travel with the result, so the last stage still holds A and effective B
    assign ovf = (r_a[NSEG-1][WIDTH-1] == r_b[NSEG-1][WIDTH-1])
              && (r_s[NSEG-1][WIDTH-1] != r_a[NSEG-1][WIDTH-1]);
`endif

endmodule

// File: tb/tb_adder_pipe.sv
// tb/tb_adder_pipe.sv - scoreboard bench for adder_pipe (32/8 and 64/16 instances)
module tb_adder_pipe;

    localparam int W    = 32;
    localparam int NSEG = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready, cin, sub, out_valid, out_ready, cout;
    logic [W-1:0]  a, b, sum;
    logic          d_in_valid, d_in_ready, d_cin, d_out_valid, d_cout;
    logic [63:0]   d_a, d_b, d_sum;
`ifdef ADDER_PIPE_OVF_EN
    logic          ovf, d_ovf;
`endif

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           edge_in;
        bit           chk_lat;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    bit   chk_lat  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    adder_pipe #(.WIDTH(32), .SEG_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout)
`ifdef ADDER_PIPE_OVF_EN
        , .ovf(ovf)
`endif
    );

    adder_pipe #(.WIDTH(64), .SEG_W(16)) dut64 (
        .clk(clk), .rst(rst), .in_valid(d_in_valid), .in_ready(d_in_ready),
        .a(d_a), .b(d_b), .cin(d_cin), .sub(1'b0),
        .out_valid(d_out_valid), .out_ready(1'b1), .sum(d_sum), .cout(d_cout)
`ifdef ADDER_PIPE_OVF_EN
        , .ovf(d_ovf)
`endif
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: integer arithmetic on the operands, signed range test for overflow
    function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                   input logic mcin, input logic msub);
        exp_t        e;
        logic [W:0]  full;
        longint      sa, sb, sres;
        sa = longint'($signed(ma));
        sb = longint'($signed(mb));
        if (msub) begin
            e.sum  = ma - mb;
            e.cout = (ma >= mb);
            sres   = sa - sb;
        end else begin
            full   = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mcin};
            e.sum  = full[W-1:0];
            e.cout = full[W];
            sres   = sa + sb + longint'(mcin);
        end
        e.ovf     = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
        e.edge_in = 0;
        e.chk_lat = 0;
        return e;
    endfunction

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                q.delete();
            end else begin
                if (out_valid && out_ready) begin
                    check("queue_nonempty", 128'(q.size() != 0), 128'(1));
                    if (q.size() != 0) begin
                        e = q.pop_front();
                        check("sum", sum, e.sum);
                        check("cout", cout, e.cout);
`ifdef ADDER_PIPE_OVF_EN
                        check("ovf", ovf, e.ovf);
`endif
                        if (e.chk_lat) check("latency", cyc + 1 - e.edge_in, NSEG);
                    end
                end
                if (in_valid && in_ready) begin
                    e = model(a, b, cin, sub);
                    e.edge_in = cyc + 1;
                    e.chk_lat = chk_lat;
                    q.push_back(e);
                end
            end
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the transfer edge
    task automatic send(input logic [W-1:0] sa, input logic [W-1:0] sb,
                        input logic scin, input logic ssub);
        bit acc;
        a = sa; b = sb; cin = scin; sub = ssub; in_valid = 1'b1;
        for (int w = 0; w < 50; w++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            if (w == 49) check("send_timeout", 128'(acc), 128'(1));
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string name, input logic [W-1:0] es, input logic ec);
        int n;
        for (n = 0; n < 20; n++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        check({name, "_timeout"}, 128'(n < 20), 128'(1));
        check({name, "_sum"}, sum, es);
        check({name, "_cout"}, cout, ec);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] held;
        int           tr, n;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        d_in_valid = 1'b0; d_a = '0; d_b = '0; d_cin = 1'b0;
        fork
            monitor();
        join_none

        idle(2);
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        check("rst_out_valid64", d_out_valid, 0);
        rst = 1'b0;
        #1;
        check("in_ready_after_reset", in_ready, 1);
        idle(1);

        // Directed: full carry ripple and subtraction with borrow
        chk_lat = 1;
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        wait_out("ripple", 32'h0000_0000, 1'b1);
        send(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1);
        wait_out("sub_borrow", 32'hFFFF_FFFE, 1'b0);
`ifdef ADDER_PIPE_OVF_EN
        send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
        for (n = 0; n < 20; n++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        check("ovf_sub", ovf, 1);
        idle(1);
`endif
        idle(4);

        // Back-to-back streaming
        for (int i = 0; i < 100; i++)
            send($urandom, $urandom, 1'($urandom), 1'($urandom));
        idle(10);
        check("drained_stream", q.size(), 0);

        // Backpressure with a full pipe
        chk_lat = 0;
        out_ready = 1'b0;
        for (int i = 0; i < NSEG; i++)
            send($urandom, $urandom, 1'($urandom), 1'($urandom));
        a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom); in_valid = 1'b1;
        @(negedge clk);
        held = sum;
        for (int i = 0; i < 6; i++) begin
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
            check("bp_sum_stable", sum, held);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(a, b, cin, sub);
        for (int i = 0; i < 3; i++)
            send($urandom, $urandom, 1'($urandom), 1'($urandom));
        idle(10);
        check("drained_bp", q.size(), 0);

        // Random valid/ready patterns
        for (int i = 0; i < 300; i++) begin
            in_valid  = 1'($urandom);
            a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            idle(1);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        idle(20);
        check("drained_random", q.size(), 0);

        // Reset with three results in flight
        chk_lat = 1;
        for (int i = 0; i < 3; i++)
            send($urandom | 32'h1, $urandom, 1'b0, 1'b0);
        idle(1);
        check("pre_reset_valid", out_valid, 1);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_sum", sum, 0);
        check("midrst_cout", cout, 0);
`ifdef ADDER_PIPE_OVF_EN
        check("midrst_ovf", ovf, 0);
`endif
        idle(1);
        rst = 1'b0;
        #1;
        check("in_ready_after_midrst", in_ready, 1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("no_stale", out_valid, 0);
        end
        idle(1);

        // 64-bit / 16-bit segments
        d_a = 64'hFFFF_FFFF_FFFF_FFFF; d_b = '0; d_cin = 1'b1; d_in_valid = 1'b1;
        @(negedge clk);
        check("w64_in_ready", d_in_ready, 1);
        tr = cyc + 1;
        @(posedge clk);
        #1;
        d_in_valid = 1'b0;
        for (n = 0; n < 20; n++) begin
            @(negedge clk);
            if (d_out_valid) break;
        end
        check("w64_latency", cyc + 1 - tr, 4);
        check("w64_sum", d_sum, 64'h0);
        check("w64_cout", d_cout, 1);
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/adder_pipe.md
ADDER_PIPE -- requirements
Module: adder_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and sum width in bits; legal values 8..128.
REQ-002 SHALL have parameter SEG_W, default 8: segment width in bits; WIDTH SHALL be an integer multiple of SEG_W.
REQ-003 SHALL derive NSEG = WIDTH/SEG_W, which is both the pipeline stage count and the latency.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  input operands present.
REQ-007 in_ready  output  1  block can accept input this cycle.
REQ-008 a  input  WIDTH  operand A.
REQ-009 b  input  WIDTH  operand B.
REQ-010 cin  input  1  carry in; ignored when sub=1.
REQ-011 sub  input  1  0: A+B+cin; 1: A-B.
REQ-012 out_valid  output  1  result present.
REQ-013 out_ready  input  1  downstream accepts the result.
REQ-014 sum  output  WIDTH  result, modulo 2^WIDTH.
REQ-015 cout  output  1  carry out of the MSB; for subtraction, 1 means no borrow.

Function
REQ-016 Stage k (0..NSEG-1) SHALL add segment k of A and of effective B, plus the carry registered by stage k-1 (stage 0 uses the effective carry in), and register SEG_W sum bits and one carry.
REQ-017 Effective B SHALL be b when sub=0 and ~b when sub=1; effective carry in SHALL be cin when sub=0 and 1 when sub=1.
REQ-018 Operand segments above stage k SHALL travel through skew registers; completed sum segments SHALL be delayed so that all WIDTH bits emerge aligned.
REQ-019 A transfer in SHALL occur when in_valid and in_ready are both 1; a transfer out SHALL occur when out_valid and out_ready are both 1.
REQ-020 The pipeline advance enable SHALL be en = !out_valid || out_ready, and in_ready SHALL equal en combinationally.
REQ-021 When en=1, every stage valid bit and its data SHALL shift one stage; stage 0 SHALL load in_valid together with the operands.
REQ-022 When en=0, all stages SHALL hold, and sum, cout and out_valid SHALL remain stable.
REQ-023 Latency SHALL be exactly NSEG cycles from input transfer to out_valid with no backpressure; sustained throughput SHALL be one result per cycle.
REQ-024 Bubbles SHALL propagate as invalid stages; bubbles need not collapse while stalled.
REQ-025 Results SHALL emerge in input order with none lost or duplicated under any in_valid/out_ready pattern.
REQ-026 A simultaneous output transfer and input transfer in the same cycle SHALL both complete.
REQ-027 When NSEG=1, the block SHALL behave as a single-register adder with latency 1.

Reset
REQ-028 While rst=1, all stage valid bits SHALL clear asynchronously.
REQ-029 While rst=1, out_valid=0, sum=0 and cout=0.
REQ-030 Data in flight SHALL be discarded by a mid-operation reset.
REQ-031 After rst deasserts, in_ready SHALL be 1 in the first cycle.

Configuration
REQ-032 Defined ADDER_PIPE_OVF_EN SHALL add output port ovf (1 bit), meaning signed two's-complement overflow.
REQ-033 ovf SHALL be (A[MSB]==Beff[MSB]) && (sum[MSB]!=A[MSB]), timed with sum and reset to 0.
REQ-034 Without ADDER_PIPE_OVF_EN, port ovf and its logic SHALL be absent and all other behaviour identical.

Verification
REQ-035 Defaults, no backpressure: a=32'hFFFF_FFFF, b=32'h0000_0001, cin=0 -> after 4 cycles sum=0, cout=1 (tests full carry ripple across segments).
REQ-036 Subtraction: a=32'h0000_0005, b=32'h0000_0007, sub=1 -> sum=32'hFFFF_FFFE, cout=0; with OVF_EN, a=32'h8000_0000, b=1, sub=1 -> ovf=1.
REQ-037 Back-to-back streaming: 100 random vectors with out_ready=1 -> 100 results in order against the reference model, one per cycle after 4-cycle fill.
REQ-038 Backpressure: out_ready held 0 for 6 cycles with pipe full -> in_ready=0, sum stable; on release, results resume in order with no loss.
REQ-039 Reset mid-flight: rst pulsed with 3 results in flight -> out_valid=0, sum=0 immediately; no stale result appears afterwards.
REQ-040 WIDTH=64, SEG_W=16, a=64'hFFFF_FFFF_FFFF_FFFF, b=0, cin=1 -> latency 4, sum=0, cout=1.
